cdb_arbiter: RTL

- Shares the single result broadcast bus (CDB) among NUM_REQ result producers: ALU, load/store unit, and branch/jump unit.
- Each producer has a DEPTH-entry FIFO. A round-robin arbiter pops one entry per cycle into a registered broadcast stage.
- The broadcast stage feeds the _cdb_ready/_cdb_rob_id/_cdb_value inputs of the reservation station, the ROB and the register file.
- Producers never collide on the bus, and a producer blocked for a cycle loses no result.

---
 rtl/cpu_defs.sv | 17 +
 rtl/cdb_req_fifo.sv | 75 +++++++
 rtl/cdb_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared by the result-bus (CDB) logic.
//   ROB_W / DATA_W : default ROB id and result widths
//   SRC_*          : producer indices on the CDB (ALU, load/store, branch)
//   SRC_W          : width of a producer index as seen on _cdb_src
package cpu_defs;

  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSB = 1;
  localparam int SRC_BR  = 2;

  localparam int NUM_SRC = SRC_BR + 1;
  localparam int SRC_W   = 2;

endpackage

// File: rtl/cdb_req_fifo.sv
// cdb_req_fifo: DEPTH-entry FIFO holding {rob_id, value} results of one
// producer while it waits for the broadcast bus.
//   clk_in, rst_in (async, active-low), rdy_in (freeze when low)
//   clear                      : synchronous flush, wins over push/pop
//   push, push_rob_id, push_value : enqueue request (dropped when full)
//   pop                        : dequeue the head entry
//   full, empty                : derived from the registered occupancy count
//   head_rob_id, head_value    : current head entry
module cdb_req_fifo #(
  parameter int DEPTH  = 2,
  parameter int ROB_W  = cpu_defs::ROB_W,
  parameter int DATA_W = cpu_defs::DATA_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              push,
  input  logic [ROB_W-1:0]  push_rob_id,
  input  logic [DATA_W-1:0] push_value,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ROB_W-1:0]  head_rob_id,
  output logic [DATA_W-1:0] head_value
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ROB_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;
  logic                    do_push;
  logic                    do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Full is judged on the pre-edge count, so a full FIFO cannot be refilled
  // in the same cycle it is popped.
  assign do_push = rdy_in && !clear && push && !full;
  assign do_pop  = rdy_in && !clear && pop && !empty;

  assign {head_rob_id, head_value} = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only read once count says valid.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= {push_rob_id, push_value};
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common data bus among NUM_REQ producers
// (0 = ALU, 1 = LSB, 2 = branch unit). Each producer feeds its own FIFO; a
// round-robin pick pops at most one head per cycle into a registered
// broadcast stage.
//   clk_in, rst_in (async, active-low), rdy_in (freeze when low)
//   _clear                        : synchronous flush of all FIFOs and the bus
//   _req_valid/_req_rob_id/_req_value : packed per-producer results
//   _req_full                     : per-producer back-pressure
//   _cdb_ready/_cdb_rob_id/_cdb_value : registered broadcast
//   _cdb_src                      : producer that won the current broadcast
module cdb_arbiter
  import cpu_defs::*;
#(
  parameter int NUM_REQ = NUM_SRC,
  parameter int DEPTH   = 2,
  parameter int ROB_W   = cpu_defs::ROB_W,
  parameter int DATA_W  = cpu_defs::DATA_W
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      _clear,
  input  logic [NUM_REQ-1:0]        _req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  _req_rob_id,
  input  logic [NUM_REQ*DATA_W-1:0] _req_value,
  output logic [NUM_REQ-1:0]        _req_full,
  output logic                      _cdb_ready,
  output logic [ROB_W-1:0]          _cdb_rob_id,
  output logic [DATA_W-1:0]         _cdb_value,
  output logic [SRC_W-1:0]          _cdb_src
);

  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] pop_sel;
  logic [ROB_W-1:0]   head_rob [NUM_REQ];
  logic [DATA_W-1:0]  head_val [NUM_REQ];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [ROB_W-1:0]   sel_rob;
  logic [DATA_W-1:0]  sel_val;
  int                 cand;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_fifo
    assign pop_sel[k] = grant_valid && (grant_idx == SRC_W'(k));

    cdb_req_fifo #(
      .DEPTH  (DEPTH),
      .ROB_W  (ROB_W),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .clear       (_clear),
      .push        (_req_valid[k]),
      .push_rob_id (_req_rob_id[k*ROB_W +: ROB_W]),
      .push_value  (_req_value[k*DATA_W +: DATA_W]),
      .pop         (pop_sel[k]),
      .full        (_req_full[k]),
      .empty       (fifo_empty[k]),
      .head_rob_id (head_rob[k]),
      .head_value  (head_val[k])
    );
  end

  // Scan producers starting at rr_ptr; the first non-empty FIFO wins. Only
  // registered FIFO state is looked at, so a same-cycle push is not seen.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_valid && !fifo_empty[SRC_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(cand);
      end
    end
  end

  assign rr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
  assign sel_rob = head_rob[grant_idx];
  assign sel_val = head_val[grant_idx];

  // Id and value registers hold when the bus is idle; only _cdb_ready drops.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      _cdb_ready  <= 1'b0;
      _cdb_rob_id <= '0;
      _cdb_value  <= '0;
      _cdb_src    <= '0;
      rr_ptr      <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        _cdb_ready <= 1'b0;
      end else if (grant_valid) begin
        _cdb_ready  <= 1'b1;
        _cdb_rob_id <= sel_rob;
        _cdb_value  <= sel_val;
        _cdb_src    <= grant_idx;
        rr_ptr      <= rr_next;
      end else begin
        _cdb_ready <= 1'b0;
      end
    end
  end

endmodule
